// File: rtl/mux_sel_pipe_if.sv
// Handshake bundle between N producers, the channel selector and one consumer.
// The master side drives channels and selection; the slave side is the selector.
interface mux_sel_pipe_if #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SEL_W = 2
);
  logic                 mode;
  logic [SEL_W-1:0]     selector;
  logic [N*WIDTH-1:0]   Data_in;
  logic [N-1:0]         in_valid;
  logic [N-1:0]         in_ready;
  logic [WIDTH-1:0]     Data_out;
  logic                 out_valid;
  logic                 out_ready;
  logic [SEL_W-1:0]     grant;

  modport master (
    output mode, selector, Data_in, in_valid, out_ready,
    input  in_ready, Data_out, out_valid, grant
  );

  modport slave (
    input  mode, selector, Data_in, in_valid, out_ready,
    output in_ready, Data_out, out_valid, grant
  );
endinterface

// File: rtl/mux_sel_pipe.sv
// N:1 operand selector with a one-deep registered output stage, chosen either
// directly by selector or round-robin over the valid channels.
module mux_sel_pipe #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SEL_W = 2
) (
  input  logic          clk,
  input  logic          reset,
  mux_sel_pipe_if.slave bus
);

  // Pointer starts on the last channel so channel 0 wins the first arbitration.
  localparam logic [SEL_W-1:0] LAST_INIT = SEL_W'(N - 1);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic [SEL_W-1:0] r_grant;
  logic [SEL_W-1:0] r_last;

  logic             w_adv;
  logic             w_hasCand;
  logic             w_xfer;
  logic [SEL_W-1:0] w_cand;
  logic [2*N-1:0]   w_dbl;
  logic [N-1:0]     w_rot;
  logic [N-1:0]     w_inReady;
  logic [WIDTH-1:0] w_candData;

  assign w_adv = !r_valid || bus.out_ready;

  // Rotating a doubled copy puts channel last+1 at bit 0 without modulo indexing.
  assign w_dbl = {bus.in_valid, bus.in_valid} >> (int'(r_last) + 1);
  assign w_rot = w_dbl[N-1:0];

  always_comb begin
    w_hasCand = 1'b0;
    w_cand    = '0;
    if (!bus.mode) begin
      if (int'(bus.selector) < N) begin
        w_hasCand = 1'b1;
        w_cand    = bus.selector;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        if (!w_hasCand && w_rot[k]) begin
          w_hasCand = 1'b1;
          w_cand    = SEL_W'((int'(r_last) + 1 + k) % N);
        end
      end
    end
  end

  // Compare-per-channel decode keeps out-of-range codes from indexing anything.
  always_comb begin
    w_inReady  = '0;
    w_candData = '0;
    for (int i = 0; i < N; i++) begin
      if (w_hasCand && (int'(w_cand) == i)) begin
        w_inReady[i] = w_adv;
        w_candData   = bus.Data_in[i*WIDTH +: WIDTH];
      end
    end
  end

  assign w_xfer = |(w_inReady & bus.in_valid);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_grant <= '0;
      r_last  <= LAST_INIT;
    end else if (w_xfer) begin
      r_data  <= w_candData;
      r_grant <= w_cand;
      r_valid <= 1'b1;
      if (bus.mode) begin
        r_last <= w_cand;
      end
    end else if (r_valid && bus.out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_inReady;
  assign bus.Data_out  = r_data;
  assign bus.out_valid = r_valid;
  assign bus.grant     = r_grant;

endmodule

// File: doc/mux_sel_pipe.md
Name: mux_sel_pipe

Overview:
- Parametrised successor to the datapath 4:1 operand selector.
- Selects one of N channels of WIDTH bits and registers the result behind a valid/ready handshake.
- Two selection modes:
  - Direct: an external selector chooses the channel, as the control unit does today.
  - Round-robin: used where several producers share one ALU operand or writeback path.

Parameters:
- WIDTH, 32, data width of each channel and of Data_out.
- N, 4, number of input channels; legal range 2 to 2^SEL_W.
- SEL_W, 2, width of selector and grant.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- mode  input  1  0 = direct select via selector; 1 = round-robin over in_valid.
- selector  input  SEL_W  channel index used in mode 0; ignored in mode 1.
- Data_in  input  N*WIDTH  packed channels; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready; combinational; at most one bit set.
- Data_out  output  WIDTH  registered selected data.
- out_valid  output  1  Data_out holds an untaken word.
- out_ready  input  1  consumer accepts Data_out this cycle.
- grant  output  SEL_W  registered index of the channel currently held in Data_out.

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - Data_out=0, out_valid=0, grant=0.
  - Round-robin pointer last=N-1, so channel 0 has first priority after reset.
  - Release is synchronous to the next clk edge.
- Advance condition: adv = !out_valid || out_ready. The output register loads only when adv=1.
- Candidate channel c is combinational:
  - mode 0: c = selector. If selector >= N, there is no candidate.
  - mode 1: c = first i with in_valid[i]=1, scanning last+1, last+2, ... modulo N. If no in_valid bit is set, there is no candidate.
- in_ready[c] = adv && candidate exists. All other in_ready bits are 0.
  - In mode 0, in_ready[selector] may be 1 while in_valid[selector]=0; no transfer occurs.
- Input transfer on channel c when in_valid[c] && in_ready[c]. At the clock edge:
  - Data_out <= channel c, grant <= c, out_valid <= 1.
  - mode 1 only: last <= c. The pointer is unchanged in mode 0 and unchanged on cycles without a transfer.
- Output transfer when out_valid && out_ready.
  - If no input transfer happens in the same cycle, out_valid <= 0. Data_out and grant hold their last values.
- Simultaneous output transfer and new input transfer: both happen. Throughput is one word per cycle; latency is one cycle from input transfer to out_valid.
- Stall (out_valid=1, out_ready=0):
  - Data_out and grant are stable and in_ready=0.
  - selector, mode and in_valid changes have no effect on held data.
- Mode change takes effect on the candidate computation in the same cycle. The pointer is retained across mode switches.
- Reset mid-stall discards the held word: out_valid=0 immediately, asynchronously.
- No X propagation: unused selector codes (>= N) give no transfer and never index out of range.

Test Plan:
1. Direct-select sweep (mode=0, N=4, WIDTH=32):
   - Stimulus: out_ready=1; Data_in channels = 0x11111111, 0x22222222, 0x33333333, 0x44444444; all in_valid=1; selector stepped 0,1,2,3 on consecutive cycles.
   - Required: Data_out = 0x11111111, 0x22222222, 0x33333333, 0x44444444 one cycle later each; grant = 0..3; out_valid=1 throughout.
2. Round-robin fairness (mode=1):
   - Stimulus: in_valid=4'b1111 held; out_ready=1.
   - Required: grant sequence 0,1,2,3,0,1; each in_ready bit is high exactly once per 4 cycles.
3. Round-robin skip:
   - Stimulus: mode=1, in_valid=4'b1010 after reset.
   - Required: grant 1,3,1,3; in_ready[0] and in_ready[2] stay 0.
4. Backpressure:
   - Stimulus: mode=1; a word from channel 2 is loaded; out_ready=0 for 3 cycles while in_valid changes; then out_ready=1 with in_valid=0.
   - Required: Data_out and grant=2 held during the stall; in_ready=0 during the stall; out_valid drops one cycle after the release edge.
5. Out-of-range select:
   - Stimulus: parameters N=3, SEL_W=2; mode=0; selector=3; in_valid=3'b111.
   - Required: in_ready=0; out_valid stays 0; Data_out unchanged.
6. Asynchronous reset mid-stall:
   - Stimulus: reset asserted between clock edges while out_valid=1 and out_ready=0.
   - Required: Data_out=0, out_valid=0, grant=0 immediately; first round-robin grant after release is channel 0 with in_valid=4'b1111.
